lsu_wb_unit: RTL

//  Load/store unit between execute and the register file. Takes one memory op per request, drives a
//  req/ack data-memory port with byte lanes, then aligns and extends load data. Loads end with a
//  one-cycle write strobe into the register file write port (RFWr/A3/WD/memOp).

---
 rtl/lsu_wb_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_wb_unit.sv
// Purpose : load/store unit between execute and the register file; drives a req/ack
//           data-memory port with byte lanes, aligns and extends load data, writes back.
// Latency : zero-wait memory -> done (and rf_wr for loads) in the cycle after the ack edge.
// Backpr. : one op in flight; i_req_valid is only taken while o_req_ready (IDLE).
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_*  / o_req_ready  request from execute (we, op, unsigned, addr, wdata, rd)
//   o_mem_*  / i_mem_*      data-memory port: req held until ack, word address, byte enables
//   o_rf_*                  register file write port (RFWr/A3/WD/memOp)
//   o_done, o_err, o_err_code  one-cycle completion / abort pulses
module lsu_wb_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_op,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rf_wr,
  output logic [4:0]  o_rf_a3,
  output logic [31:0] o_rf_wd,
  output logic [1:0]  o_rf_memop,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic          r_we, r_unsigned;
  logic [1:0]    r_op, r_lane;
  logic [4:0]    r_rd;
  logic [31:0]   r_mem_addr, r_mem_wdata, r_rf_wd;
  logic [3:0]    r_mem_be;
  logic [4:0]    r_rf_a3;
  logic [CW-1:0] r_cnt;
  logic          r_err, r_st_done;
  logic [1:0]    r_err_code;

  logic        w_accept, w_illegal, w_misal, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ext;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_illegal = (i_req_op == 2'b11);
  assign w_misal   = ((i_req_op == 2'b01) && i_req_addr[0]) ||
                     ((i_req_op == 2'b10) && (i_req_addr[1:0] != 2'b00));
  // Ack in the last allowed cycle takes priority over the abort.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1)) && !i_mem_ack;

  // Byte lanes and replicated store data for the incoming request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_req_wdata;
    case (i_req_op)
      2'b00: begin
        w_be    = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Align the addressed lane down to bit 0, then extend.
  assign w_shift = i_mem_rdata >> {r_lane, 3'b000};
  always_comb begin
    w_ext = i_mem_rdata;
    case (r_op)
      2'b00:   w_ext = r_unsigned ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ext = r_unsigned ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_illegal && !w_misal) w_next = S_ACCESS;
      S_ACCESS: begin
        if (i_mem_ack)      w_next = r_we ? S_IDLE : S_WB;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath and pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_op        <= 2'b00;
      r_lane      <= 2'b00;
      r_rd        <= 5'd0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rf_a3     <= 5'd0;
      r_rf_wd     <= 32'd0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
      r_st_done   <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_st_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_err      <= 1'b1;
              r_err_code <= 2'b11;
            end else if (w_misal) begin
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
            end else begin
              r_we        <= i_req_we;
              r_unsigned  <= i_req_unsigned;
              r_op        <= i_req_op;
              r_lane      <= i_req_addr[1:0];
              r_rd        <= i_req_rd;
              r_mem_addr  <= {i_req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_cnt       <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ack) begin
            if (r_we) begin
              r_st_done <= 1'b1;
            end else begin
              r_rf_wd <= w_ext;
              r_rf_a3 <= r_rd;
            end
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_req_ready = (r_state == S_IDLE);
    o_mem_req   = (r_state == S_ACCESS);
    o_mem_we    = (r_state == S_ACCESS) && r_we;
    o_mem_addr  = r_mem_addr;
    o_mem_be    = r_mem_be;
    o_mem_wdata = r_mem_wdata;
    o_rf_wr     = (r_state == S_WB) && (r_rd != 5'd0);
    o_rf_a3     = r_rf_a3;
    o_rf_wd     = r_rf_wd;
    o_rf_memop  = 2'b10;
    o_done      = (r_state == S_WB) || r_st_done;
    o_err       = r_err;
    o_err_code  = r_err_code;
  end

endmodule
